de1_blinker_nios2_proc_dct_packer: RTL and testbench
====================================================

# de1_blinker_nios2_proc_dct_packer

Packs the 2-bit direct-control-transfer (DCT) codes retired by the Nios II core into 30-bit, 15-code trace frames for the OCI trace path. The block sits directly upstream of the OCI test-bench monitor, which consumes its live `dct_buffer`/`dct_count` outputs. Completed frames are handed downstream through a single-entry valid/ready output register. The block accounts for backpressure, flushes and dropped codes.

## Interface
- `FLUSH_ON_DISABLE`, default 1: when 1, a 1→0 transition of `trace_enable` acts as a flush request.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `trace_enable` in 1: when low, incoming codes are ignored. Ignored codes are not counted as drops.
- `dct_valid` in 1: one DCT code presented this cycle.
- `dct_code` in 2: DCT code (01 taken, 10 not-taken, 11 exception, 00 reserved but packed as-is).
- `flush` in 1: single-cycle request to emit the partial buffer.
- `frame_ready` in 1: downstream accepts the frame this cycle.
- `frame_valid` out 1: output frame register holds a frame.
- `frame_buffer` out 30: packed codes of the frame.
- `frame_count` out 4: number of codes in the frame (1–15).
- `frame_overflow` out 1: at least one code was dropped before this frame was emitted.
- `dct_buffer` out 30: live packing buffer, for the test-bench monitor.
- `dct_count` out 4: live code count, 0–15, for the test-bench monitor.

## Operation
- Packing rule: each accepted code gives `dct_buffer <= {dct_code, dct_buffer[29:2]}` and `dct_count <= dct_count+1`.
  - The newest code sits in bits [29:28].
  - With n codes, the oldest code is at bits [31-2n:30-2n]; bits below it are 0.
- `slot_free` = !frame_valid | frame_ready.
- `flush_req` = flush | flush_pending | (FLUSH_ON_DISABLE & trace_enable falling edge, taken from a registered copy of `trace_enable`).
- Emit condition: `emit` = slot_free & ((dct_count==15) | (flush_req & dct_count!=0)).
- On emit:
  - `frame_buffer<=dct_buffer`, `frame_count<=dct_count`, `frame_overflow<=ovf_sticky`, `frame_valid<=1`.
  - The live buffer, count, `ovf_sticky` and `flush_pending` all clear.
- Accept condition: `accept` = trace_enable & dct_valid & (dct_count!=15 | emit).
  - A code accepted in an emit cycle is packed into the cleared buffer: `dct_buffer<={dct_code,28'b0}`, `dct_count<=1`.
  - That code starts the next frame. Flush always closes the frame that existed before the cycle.
- Drop: trace_enable & dct_valid & dct_count==15 & !emit sets `ovf_sticky`. Buffer and count hold.
- Flush request while `dct_count!=0` and !slot_free: `flush_pending<=1`, held until emit.
  - Codes accepted meanwhile join the pending frame, up to 15.
- Flush request with `dct_count==0`: discarded; no empty frame is ever emitted.
- Frame handshake:
  - A frame leaves when frame_valid & frame_ready.
  - If no emit occurs in that cycle, `frame_valid<=0`.
  - `frame_buffer`, `frame_count` and `frame_overflow` are stable while frame_valid & !frame_ready.
- Internal states: COLLECT (count 0–14), FULL (count 15, waiting for slot_free), PENDING_FLUSH (flush_pending=1). The output slot is either EMPTY or HELD.

## Timing
- Reset, asynchronous: all outputs and internal registers clear immediately.
  - frame_valid=0, frame_buffer=0, frame_count=0, frame_overflow=0, dct_buffer=0, dct_count=0.
  - flush_pending=0, ovf_sticky=0, registered trace_enable=0.
- Reset asserted mid-frame discards both the live buffer and the held frame.
- Live outputs update on the edge after accept, i.e. 1-cycle latency.
- 15th code accepted at edge N: `dct_count==15` is visible after N. Emit happens at edge N+1 if slot_free, so `frame_valid` is high after N+1.
- Flush pulse in cycle N with slot free and count>0: `frame_valid` is high after edge N.
- Back-to-back throughput: one frame per cycle sustained when frame_ready is held high.

## Test plan
- Fifteen codes of 11 with ready=1:
  - `frame_valid` rises one edge after `dct_count` shows 15.
  - Frame contents: `frame_buffer`=30'h3FFFFFFF, `frame_count`=15, `frame_overflow`=0.
  - Live count returns to 0.
- Codes 01, 10, 11, then a flush pulse:
  - Frame contents: `frame_buffer`=30'h39000000, `frame_count`=3.
  - Flush with `dct_count`=0 produces no frame.
- ready=0, then 34 codes of 01:
  - First frame (count 15) is held stable, and the second buffer fills to 15.
  - 4 codes are dropped. The second frame, seen after ready rises, has `frame_overflow`=1 and `frame_count`=15.
- Stalled at count 15 with frame_ready=1 and a code 10 in the same cycle:
  - Frame emitted, and live `dct_buffer`=30'h20000000 with `dct_count`=1.
- trace_enable=0 with codes applied: no change and no overflow. With `FLUSH_ON_DISABLE`=1, 5 codes then trace_enable falling emits a frame with `frame_count`=5.
- reset pulse mid-operation (frame held, count 7): all outputs 0 immediately. The next code after reset gives `dct_count`=1.

Source files
------------

// File: rtl/de1_blinker_nios2_proc_dct_packer.sv
// DCT trace packer: packs 2-bit DCT codes into 30-bit, 15-code frames.
// Ports: trace_enable/dct_valid/dct_code in, flush, frame_* out, dct_* live.
module de1_blinker_nios2_proc_dct_packer #(
    parameter bit FLUSH_ON_DISABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trace_enable,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    input  logic        flush,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [29:0] frame_buffer,
    output logic [3:0]  frame_count,
    output logic        frame_overflow,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count
);

    typedef enum logic [1:0] {
        COLLECT,
        FULL,
        PENDING_FLUSH
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        ovf_sticky;
    logic        ovf_nx;
    logic        te_q;
    logic [29:0] buf_nx;
    logic [3:0]  cnt_nx;

    logic full;
    logic nonempty;
    logic te_fall;
    logic flush_pending;
    logic flush_req;
    logic slot_free;
    logic emit;
    logic accept;
    logic drop;

    assign full          = (dct_count == 4'd15);
    assign nonempty      = (dct_count != 4'd0);
    assign te_fall       = FLUSH_ON_DISABLE & te_q & ~trace_enable;
    assign flush_pending = (state == PENDING_FLUSH);
    assign flush_req     = flush | flush_pending | te_fall;
    assign slot_free     = ~frame_valid | frame_ready;
    assign emit          = slot_free & (full | (flush_req & nonempty));
    assign accept        = trace_enable & dct_valid & (~full | emit);
    assign drop          = trace_enable & dct_valid & full & ~emit;

    // Emit clears first, so a code accepted in the same cycle lands
    // in an empty buffer and opens the next frame.
    always_comb begin
        buf_nx   = dct_buffer;
        cnt_nx   = dct_count;
        ovf_nx   = ovf_sticky;
        state_nx = state;
        if (emit) begin
            buf_nx = '0;
            cnt_nx = '0;
            ovf_nx = 1'b0;
        end
        if (accept) begin
            buf_nx = {dct_code, buf_nx[29:2]};
            cnt_nx = cnt_nx + 4'd1;
        end
        if (drop) begin
            ovf_nx = 1'b1;
        end
        if (emit) begin
            state_nx = COLLECT;
        end else if (flush_pending
                     | (flush_req & nonempty & ~slot_free)) begin
            state_nx = PENDING_FLUSH;
        end else if (cnt_nx == 4'd15) begin
            state_nx = FULL;
        end else begin
            state_nx = COLLECT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= COLLECT;
            dct_buffer <= '0;
            dct_count  <= '0;
            ovf_sticky <= 1'b0;
            te_q       <= 1'b0;
        end else begin
            state      <= state_nx;
            dct_buffer <= buf_nx;
            dct_count  <= cnt_nx;
            ovf_sticky <= ovf_nx;
            te_q       <= trace_enable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_valid    <= 1'b0;
            frame_buffer   <= '0;
            frame_count    <= '0;
            frame_overflow <= 1'b0;
        end else if (emit) begin
            frame_valid    <= 1'b1;
            frame_buffer   <= dct_buffer;
            frame_count    <= dct_count;
            frame_overflow <= ovf_sticky;
        end else if (frame_valid & frame_ready) begin
            frame_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_de1_blinker_nios2_proc_dct_packer.sv
// Directed self-checking bench for the DCT trace packer.
// Drives inputs 1ns after the rising edge and checks in the same window.
module tb_de1_blinker_nios2_proc_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_enable;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        flush;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] frame_buffer;
    logic [3:0]  frame_count;
    logic        frame_overflow;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;

    int checks = 0;
    int errors = 0;

    de1_blinker_nios2_proc_dct_packer #(.FLUSH_ON_DISABLE(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .trace_enable(trace_enable),
        .dct_valid(dct_valid),
        .dct_code(dct_code),
        .flush(flush),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .frame_buffer(frame_buffer),
        .frame_count(frame_count),
        .frame_overflow(frame_overflow),
        .dct_buffer(dct_buffer),
        .dct_count(dct_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then land 1ns after the next edge.
    task automatic step(input logic te, input logic v, input logic [1:0] c,
                        input logic fl, input logic rdy);
        trace_enable = te;
        dct_valid    = v;
        dct_code     = c;
        flush        = fl;
        frame_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic codes(input int n, input logic [1:0] c,
                         input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, c, 1'b0, rdy);
    endtask

    initial begin
        reset        = 1'b1;
        trace_enable = 1'b1;
        dct_valid    = 1'b0;
        dct_code     = 2'b00;
        flush        = 1'b0;
        frame_ready  = 1'b1;
        #3;
        check("rst_fv", {31'd0, frame_valid}, 32'd0);
        check("rst_cnt", {28'd0, dct_count}, 32'd0);
        check("rst_buf", {2'd0, dct_buffer}, 32'd0);
        check("rst_fbuf", {2'd0, frame_buffer}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fifteen codes of 11, ready high
        codes(15, 2'b11, 1'b1);
        check("full_cnt", {28'd0, dct_count}, 32'd15);
        check("full_fv0", {31'd0, frame_valid}, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        check("f1_fv", {31'd0, frame_valid}, 32'd1);
        check("f1_buf", {2'd0, frame_buffer}, 32'h3FFFFFFF);
        check("f1_cnt", {28'd0, frame_count}, 32'd15);
        check("f1_ovf", {31'd0, frame_overflow}, 32'd0);
        check("f1_live", {28'd0, dct_count}, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        check("f1_gone", {31'd0, frame_valid}, 32'd0);

        // 01, 10, 11 then flush
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
        check("pk_buf2", {2'd0, dct_buffer}, 32'h24000000);
        step(1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
        check("pk_buf3", {2'd0, dct_buffer}, 32'h39000000);
        step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        check("fl_fv", {31'd0, frame_valid}, 32'd1);
        check("fl_buf", {2'd0, frame_buffer}, 32'h39000000);
        check("fl_cnt", {28'd0, frame_count}, 32'd3);
        step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        check("fl_empty", {31'd0, frame_valid}, 32'd0);

        // Backpressure: 34 codes of 01 with ready low
        codes(20, 2'b01, 1'b0);
        check("bp_fv", {31'd0, frame_valid}, 32'd1);
        check("bp_hold", {2'd0, frame_buffer}, 32'h15555555);
        codes(14, 2'b01, 1'b0);
        check("bp_cnt", {28'd0, dct_count}, 32'd15);
        check("bp_hold2", {2'd0, frame_buffer}, 32'h15555555);
        check("bp_fcnt", {28'd0, frame_count}, 32'd15);
        check("bp_ovf0", {31'd0, frame_overflow}, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        check("bp2_fv", {31'd0, frame_valid}, 32'd1);
        check("bp2_ovf", {31'd0, frame_overflow}, 32'd1);
        check("bp2_cnt", {28'd0, frame_count}, 32'd15);
        check("bp2_live", {28'd0, dct_count}, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        check("bp2_gone", {31'd0, frame_valid}, 32'd0);

        // Stall at 15 then release with a code in the same cycle
        codes(15, 2'b01, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        codes(15, 2'b11, 1'b0);
        check("st_cnt", {28'd0, dct_count}, 32'd15);
        step(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
        check("st_fbuf", {2'd0, frame_buffer}, 32'h3FFFFFFF);
        check("st_buf", {2'd0, dct_buffer}, 32'h20000000);
        check("st_cnt1", {28'd0, dct_count}, 32'd1);
        step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        check("st_fl_cnt", {28'd0, frame_count}, 32'd1);
        check("st_fl_ovf", {31'd0, frame_overflow}, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

        // Trace disabled: codes ignored
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b11, 1'b0, 1'b1);
        check("dis_cnt", {28'd0, dct_count}, 32'd0);
        check("dis_fv", {31'd0, frame_valid}, 32'd0);
        codes(5, 2'b10, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        check("dis_fv1", {31'd0, frame_valid}, 32'd1);
        check("dis_fcnt", {28'd0, frame_count}, 32'd5);
        check("dis_fbuf", {2'd0, frame_buffer}, 32'h2AA00000);
        check("dis_ovf", {31'd0, frame_overflow}, 32'd0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);

        // Reset mid-operation: frame held, count 7
        codes(15, 2'b01, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        codes(7, 2'b11, 1'b0);
        check("pre_cnt", {28'd0, dct_count}, 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("ar_fv", {31'd0, frame_valid}, 32'd0);
        check("ar_cnt", {28'd0, dct_count}, 32'd0);
        check("ar_buf", {2'd0, dct_buffer}, 32'h0);
        check("ar_fbuf", {2'd0, frame_buffer}, 32'h0);
        check("ar_fcnt", {28'd0, frame_count}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        check("post_cnt", {28'd0, dct_count}, 32'd1);
        check("post_fv", {31'd0, frame_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
